// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges the in-order pipeline writeback (m0)
// and the long-latency unit writeback (m1) onto one registered write port.
module regfile_wb_arbiter #(
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [4:0]      m0_rd,
  input  logic [XLEN-1:0] m0_wd,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [4:0]      m1_rd,
  input  logic [XLEN-1:0] m1_wd,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_wd,
  output logic            starve_active
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {
    SRC_M0 = 1'b0,
    SRC_M1 = 1'b1
  } src_t;

  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_nxt;
  src_t            rr_last;
  src_t            win;
  logic            starve_hit;
  logic            acc;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_wd;

  // Pick the winner for this cycle and derive the handshake from it
  always_comb begin
    win        = SRC_M0;
    starve_hit = (starve_cnt == SMAX);
    if (m0_valid && m1_valid) begin
      if (ARB_MODE == 0) begin
        win = starve_hit ? SRC_M1 : SRC_M0;
      end else begin
        win = (rr_last == SRC_M0) ? SRC_M1 : SRC_M0;
      end
    end else if (m1_valid) begin
      win = SRC_M1;
    end
    m0_ready      = !rst && m0_valid && (win == SRC_M0);
    m1_ready      = !rst && m1_valid && (win == SRC_M1);
    acc           = m0_ready || m1_ready;
    sel_rd        = (win == SRC_M1) ? m1_rd : m0_rd;
    sel_wd        = (win == SRC_M1) ? m1_wd : m0_wd;
    starve_active = (ARB_MODE == 0) && starve_hit && m1_valid;
  end

  // Aging counter: counts cycles m1 waits while valid, saturating at the limit
  always_comb begin
    starve_nxt = '0;
    if (ARB_MODE == 0 && m1_valid && !m1_ready) begin
      starve_nxt = starve_hit ? starve_cnt : starve_cnt + CW'(1);
    end
  end

  // Arbiter state and registered write port; x0 writes are latched but not enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_wd      <= '0;
      starve_cnt <= '0;
      rr_last    <= SRC_M1;
    end else begin
      starve_cnt <= starve_nxt;
      if (acc) begin
        wb_we   <= (sel_rd != 5'd0);
        wb_rd   <= sel_rd;
        wb_wd   <= sel_wd;
        rr_last <= win;
      end else begin
        wb_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: one aging-mode and one round-robin
// instance share the same stimulus; each step compares against hand-derived values.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [4:0]  m0_rd, m1_rd;
  logic [31:0] m0_wd, m1_wd;

  logic        a_m0_ready, a_m1_ready, a_wb_we, a_starve_active;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_wd;
  logic        b_m0_ready, b_m1_ready, b_wb_we, b_starve_active;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_wd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ARB_MODE(0), .STARVE_MAX(4), .XLEN(32)) u_age (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_rd(m0_rd), .m0_wd(m0_wd),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_rd(m1_rd), .m1_wd(m1_wd),
    .wb_we(a_wb_we), .wb_rd(a_wb_rd), .wb_wd(a_wb_wd), .starve_active(a_starve_active)
  );

  regfile_wb_arbiter #(.ARB_MODE(1), .STARVE_MAX(4), .XLEN(32)) u_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_rd(m0_rd), .m0_wd(m0_wd),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_rd(m1_rd), .m1_wd(m1_wd),
    .wb_we(b_wb_we), .wb_rd(b_wb_rd), .wb_wd(b_wb_wd), .starve_active(b_starve_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with both sources requesting
    rst = 1'b1;
    m0_valid = 1'b1; m0_rd = 5'd3; m0_wd = 32'h1111_1111;
    m1_valid = 1'b1; m1_rd = 5'd7; m1_wd = 32'h2222_2222;
    tick();
    tick();
    #1;
    chk("rst_a_m0_ready", a_m0_ready, 0);
    chk("rst_a_m1_ready", a_m1_ready, 0);
    chk("rst_a_wb_we", a_wb_we, 0);
    chk("rst_a_wb_rd", a_wb_rd, 0);
    chk("rst_a_wb_wd", a_wb_wd, 0);
    chk("rst_b_m0_ready", b_m0_ready, 0);
    chk("rst_b_m1_ready", b_m1_ready, 0);
    chk("rst_b_wb_we", b_wb_we, 0);
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_a_wb_we", a_wb_we, 0);

    // 2. single source m1
    m1_valid = 1'b1; m1_rd = 5'd5; m1_wd = 32'hDEAD_BEEF;
    #1;
    chk("single_a_m1_ready", a_m1_ready, 1);
    chk("single_a_m0_ready", a_m0_ready, 0);
    chk("single_b_m1_ready", b_m1_ready, 1);
    tick();
    chk("single_a_wb_we", a_wb_we, 1);
    chk("single_a_wb_rd", a_wb_rd, 5);
    chk("single_a_wb_wd", a_wb_wd, 32'hDEAD_BEEF);
    chk("single_b_wb_wd", b_wb_wd, 32'hDEAD_BEEF);
    m1_valid = 1'b0;
    tick();
    chk("hold_a_wb_we", a_wb_we, 0);
    chk("hold_a_wb_rd", a_wb_rd, 5);
    chk("hold_a_wb_wd", a_wb_wd, 32'hDEAD_BEEF);

    // 3. aging: m0 wins four times, then m1 is forced through
    m0_valid = 1'b1; m0_rd = 5'd3;
    m1_valid = 1'b1; m1_rd = 5'd7; m1_wd = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      m0_wd = 32'hA000_0000 + i;
      #1;
      chk("age_m0_ready", a_m0_ready, 1);
      chk("age_m1_ready", a_m1_ready, 0);
      chk("age_starve_off", a_starve_active, 0);
      tick();
      chk("age_wb_rd_m0", a_wb_rd, 3);
      chk("age_wb_wd_m0", a_wb_wd, 32'hA000_0000 + i);
    end
    #1;
    chk("age_force_m1_ready", a_m1_ready, 1);
    chk("age_force_m0_ready", a_m0_ready, 0);
    chk("age_force_starve", a_starve_active, 1);
    tick();
    chk("age_force_wb_rd", a_wb_rd, 7);
    chk("age_force_wb_wd", a_wb_wd, 32'hB000_0000);
    chk("age_force_wb_we", a_wb_we, 1);
    #1;
    chk("age_after_starve", a_starve_active, 0);
    chk("age_after_m0_ready", a_m0_ready, 1);
    m0_valid = 1'b0; m1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 4. round-robin alternation after reset (m0 wins first tie)
    m0_valid = 1'b1; m0_rd = 5'd10; m0_wd = 32'h10;
    m1_valid = 1'b1; m1_rd = 5'd20; m1_wd = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_m0_ready", b_m0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_m1_ready", b_m1_ready, (i % 2 == 1) ? 1 : 0);
      chk("rr_starve_off", b_starve_active, 0);
      tick();
      chk("rr_wb_rd", b_wb_rd, (i % 2 == 0) ? 10 : 20);
      chk("rr_wb_wd", b_wb_wd, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk("rr_wb_we", b_wb_we, 1);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();

    // 5. x0 write accepted but not enabled
    m0_valid = 1'b1; m0_rd = 5'd0; m0_wd = 32'h1234;
    #1;
    chk("x0_m0_ready", a_m0_ready, 1);
    tick();
    chk("x0_wb_we", a_wb_we, 0);
    chk("x0_wb_rd", a_wb_rd, 0);
    chk("x0_wb_wd", a_wb_wd, 32'h1234);
    m0_valid = 1'b0;
    tick();

    // 6. reset mid-stream with a partially aged counter
    m0_valid = 1'b1; m0_rd = 5'd9; m0_wd = 32'h99;
    m1_valid = 1'b1; m1_rd = 5'd7; m1_wd = 32'h77;
    tick();
    tick();
    tick();
    chk("mid_wb_we_before", a_wb_we, 1);
    chk("mid_wb_rd_before", a_wb_rd, 9);
    rst = 1'b1;
    #1;
    chk("mid_rst_m0_ready", a_m0_ready, 0);
    chk("mid_rst_m1_ready", a_m1_ready, 0);
    tick();
    chk("mid_wb_we", a_wb_we, 0);
    chk("mid_wb_rd", a_wb_rd, 0);
    chk("mid_wb_wd", a_wb_wd, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mid_age_m0_ready", a_m0_ready, 1);
      chk("mid_age_starve_off", a_starve_active, 0);
      tick();
    end
    #1;
    chk("mid_age_m1_ready", a_m1_ready, 1);
    chk("mid_age_starve", a_starve_active, 1);
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
